// File: rtl/lbus_rx_stats.sv
// LBUS receive statistics: walks segments in order, tracks frame boundaries across cycles,
// accumulates saturating frame/byte/error/runt/oversize counters and sticky protocol flags.
module lbus_rx_stats #(
   parameter int unsigned SEGMENTS  = 4,
   parameter int unsigned SEG_BYTES = 16,
   parameter int unsigned CNT_WIDTH = 48,
   parameter int unsigned MIN_LEN   = 64,
   parameter int unsigned MTU       = 16383
) (
   input  logic                                   CLK,
   input  logic                                   RESET_N,
   input  logic [SEGMENTS-1:0]                    RX_ENA,
   input  logic [SEGMENTS-1:0]                    RX_SOP,
   input  logic [SEGMENTS-1:0]                    RX_EOP,
   input  logic [SEGMENTS-1:0]                    RX_ERR,
   input  logic [SEGMENTS*$clog2(SEG_BYTES)-1:0]  RX_MTY,
   input  logic                                   SNAPSHOT,
   input  logic                                   CLEAR,
   output logic [CNT_WIDTH-1:0]                   CNT_FRAMES,
   output logic [CNT_WIDTH-1:0]                   CNT_BYTES,
   output logic [CNT_WIDTH-1:0]                   CNT_ERR,
   output logic [CNT_WIDTH-1:0]                   CNT_RUNT,
   output logic [CNT_WIDTH-1:0]                   CNT_OVERSIZE,
   output logic                                   SNAP_VALID,
   output logic [3:0]                             PROTO_VIOL
);

   localparam int unsigned MTY_W = $clog2(SEG_BYTES);
   localparam int unsigned LEN_W = 16;
   localparam int unsigned EVT_W = $clog2(2*SEGMENTS+1);
   localparam int unsigned SUM_W = LEN_W + $clog2(SEGMENTS+1);
   localparam int unsigned ACC_W = ((CNT_WIDTH > SUM_W) ? CNT_WIDTH : SUM_W) + 1;

   typedef enum logic {ST_IDLE, ST_IN_FRAME} frame_state_e;

   function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] a,
                                                input logic [LEN_W-1:0] b);
      logic [LEN_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[LEN_W] ? '1 : s[LEN_W-1:0];
   endfunction

   function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] cnt,
                                                    input logic [ACC_W-1:0]     inc);
      logic [ACC_W-1:0] s;
      s = ACC_W'(cnt) + inc;
      return (s > ACC_W'({CNT_WIDTH{1'b1}})) ? '1 : CNT_WIDTH'(s);
   endfunction

   // Stage 1: input register
   logic [SEGMENTS-1:0]       ena_q, sop_q, eop_q, err_q;
   logic [SEGMENTS*MTY_W-1:0] mty_q;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         ena_q <= '0;
         sop_q <= '0;
         eop_q <= '0;
         err_q <= '0;
         mty_q <= '0;
      end else begin
         ena_q <= RX_ENA;
         sop_q <= RX_SOP;
         eop_q <= RX_EOP;
         err_q <= RX_ERR;
         mty_q <= RX_MTY;
      end
   end

   // Stage 2: in-order segment walk producing this cycle's closure events
   frame_state_e         state_q, state_d;
   logic [LEN_W-1:0]     len_q, len_d;
   logic [EVT_W-1:0]     evt_frames, evt_err, evt_runt, evt_over;
   logic [SUM_W-1:0]     evt_bytes;
   logic [3:0]           evt_viol;

   always_comb begin
      frame_state_e     st_v;
      logic [LEN_W-1:0] len_v;
      logic [LEN_W-1:0] seg_len;
      logic [MTY_W-1:0] mty_i;
      logic             close;
      logic             gap;

      st_v       = state_q;
      len_v      = len_q;
      evt_frames = '0;
      evt_err    = '0;
      evt_runt   = '0;
      evt_over   = '0;
      evt_bytes  = '0;
      evt_viol   = '0;
      gap        = 1'b0;

      for (int i = 0; i < SEGMENTS; i++) begin
         mty_i   = mty_q[i*MTY_W +: MTY_W];
         seg_len = eop_q[i] ? LEN_W'(SEG_BYTES) - LEN_W'(mty_i) : LEN_W'(SEG_BYTES);
         close   = 1'b0;
         if (!ena_q[i]) begin
            gap = 1'b1;
         end else begin
            if (gap) evt_viol[2] = 1'b1;
            if (!eop_q[i] && (mty_i != '0)) evt_viol[3] = 1'b1;
            if (sop_q[i]) begin
               // A new SOP abandons any open frame as an error
               if (st_v == ST_IN_FRAME) begin
                  evt_viol[0] = 1'b1;
                  evt_err     = evt_err + EVT_W'(1);
               end
               st_v  = ST_IN_FRAME;
               len_v = seg_len;
               close = eop_q[i];
            end else if (st_v == ST_IN_FRAME) begin
               len_v = sat_len(len_v, seg_len);
               close = eop_q[i];
            end else begin
               evt_viol[1] = 1'b1;
            end
            if (close) begin
               st_v = ST_IDLE;
               if (err_q[i]) begin
                  evt_err = evt_err + EVT_W'(1);
               end else begin
                  evt_frames = evt_frames + EVT_W'(1);
                  evt_bytes  = evt_bytes + SUM_W'(len_v);
               end
               if (len_v < LEN_W'(MIN_LEN)) evt_runt = evt_runt + EVT_W'(1);
               if (len_v > LEN_W'(MTU))     evt_over = evt_over + EVT_W'(1);
            end
         end
      end

      state_d = st_v;
      len_d   = len_v;
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
      end
   end

   // Stage 3: live counters, sticky flags and snapshot outputs
   logic [CNT_WIDTH-1:0] live_frames_q, live_frames_d;
   logic [CNT_WIDTH-1:0] live_bytes_q,  live_bytes_d;
   logic [CNT_WIDTH-1:0] live_err_q,    live_err_d;
   logic [CNT_WIDTH-1:0] live_runt_q,   live_runt_d;
   logic [CNT_WIDTH-1:0] live_over_q,   live_over_d;
   logic [3:0]           viol_q,        viol_d;
   logic [CNT_WIDTH-1:0] cnt_frames_q,  cnt_frames_d;
   logic [CNT_WIDTH-1:0] cnt_bytes_q,   cnt_bytes_d;
   logic [CNT_WIDTH-1:0] cnt_err_q,     cnt_err_d;
   logic [CNT_WIDTH-1:0] cnt_runt_q,    cnt_runt_d;
   logic [CNT_WIDTH-1:0] cnt_over_q,    cnt_over_d;
   logic                 snap_valid_q,  snap_valid_d;

   always_comb begin
      live_frames_d = sat_add(live_frames_q, ACC_W'(evt_frames));
      live_bytes_d  = sat_add(live_bytes_q,  ACC_W'(evt_bytes));
      live_err_d    = sat_add(live_err_q,    ACC_W'(evt_err));
      live_runt_d   = sat_add(live_runt_q,   ACC_W'(evt_runt));
      live_over_d   = sat_add(live_over_q,   ACC_W'(evt_over));
      viol_d        = viol_q | evt_viol;
      cnt_frames_d  = cnt_frames_q;
      cnt_bytes_d   = cnt_bytes_q;
      cnt_err_d     = cnt_err_q;
      cnt_runt_d    = cnt_runt_q;
      cnt_over_d    = cnt_over_q;
      snap_valid_d  = SNAPSHOT;

      // Snapshot reads the registered live values, so it sees pre-clear counts
      if (SNAPSHOT) begin
         cnt_frames_d = live_frames_q;
         cnt_bytes_d  = live_bytes_q;
         cnt_err_d    = live_err_q;
         cnt_runt_d   = live_runt_q;
         cnt_over_d   = live_over_q;
      end
      if (CLEAR) begin
         live_frames_d = '0;
         live_bytes_d  = '0;
         live_err_d    = '0;
         live_runt_d   = '0;
         live_over_d   = '0;
         viol_d        = '0;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         live_frames_q <= '0;
         live_bytes_q  <= '0;
         live_err_q    <= '0;
         live_runt_q   <= '0;
         live_over_q   <= '0;
         viol_q        <= '0;
         cnt_frames_q  <= '0;
         cnt_bytes_q   <= '0;
         cnt_err_q     <= '0;
         cnt_runt_q    <= '0;
         cnt_over_q    <= '0;
         snap_valid_q  <= 1'b0;
      end else begin
         live_frames_q <= live_frames_d;
         live_bytes_q  <= live_bytes_d;
         live_err_q    <= live_err_d;
         live_runt_q   <= live_runt_d;
         live_over_q   <= live_over_d;
         viol_q        <= viol_d;
         cnt_frames_q  <= cnt_frames_d;
         cnt_bytes_q   <= cnt_bytes_d;
         cnt_err_q     <= cnt_err_d;
         cnt_runt_q    <= cnt_runt_d;
         cnt_over_q    <= cnt_over_d;
         snap_valid_q  <= snap_valid_d;
      end
   end

   assign CNT_FRAMES   = cnt_frames_q;
   assign CNT_BYTES    = cnt_bytes_q;
   assign CNT_ERR      = cnt_err_q;
   assign CNT_RUNT     = cnt_runt_q;
   assign CNT_OVERSIZE = cnt_over_q;
   assign SNAP_VALID   = snap_valid_q;
   assign PROTO_VIOL   = viol_q;

endmodule

// File: tb/tb_lbus_rx_stats.sv
// Directed bench for lbus_rx_stats: a 48-bit instance plus an 8-bit instance for saturation.
module tb_lbus_rx_stats;

   localparam int unsigned S = 4;

   logic          CLK;
   logic          RESET_N;
   logic [S-1:0]  rx_ena, rx_sop, rx_eop, rx_err;
   logic [S*4-1:0] rx_mty;
   logic          snapshot, clear;

   logic [47:0] c_frames, c_bytes, c_err, c_runt, c_over;
   logic        snap_valid;
   logic [3:0]  viol;
   logic [7:0]  s_frames, s_bytes, s_err, s_runt, s_over;
   logic        s_snap_valid;
   logic [3:0]  s_viol;

   int checks   = 0;
   int failures = 0;

   lbus_rx_stats u_dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .RX_ENA(rx_ena), .RX_SOP(rx_sop), .RX_EOP(rx_eop), .RX_ERR(rx_err), .RX_MTY(rx_mty),
      .SNAPSHOT(snapshot), .CLEAR(clear),
      .CNT_FRAMES(c_frames), .CNT_BYTES(c_bytes), .CNT_ERR(c_err), .CNT_RUNT(c_runt),
      .CNT_OVERSIZE(c_over), .SNAP_VALID(snap_valid), .PROTO_VIOL(viol)
   );

   lbus_rx_stats #(.CNT_WIDTH(8)) u_dut8 (
      .CLK(CLK), .RESET_N(RESET_N),
      .RX_ENA(rx_ena), .RX_SOP(rx_sop), .RX_EOP(rx_eop), .RX_ERR(rx_err), .RX_MTY(rx_mty),
      .SNAPSHOT(snapshot), .CLEAR(clear),
      .CNT_FRAMES(s_frames), .CNT_BYTES(s_bytes), .CNT_ERR(s_err), .CNT_RUNT(s_runt),
      .CNT_OVERSIZE(s_over), .SNAP_VALID(s_snap_valid), .PROTO_VIOL(s_viol)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [S-1:0] ena, input logic [S-1:0] sop,
                        input logic [S-1:0] eop, input logic [S-1:0] err,
                        input logic [S*4-1:0] mty);
      rx_ena = ena; rx_sop = sop; rx_eop = eop; rx_err = err; rx_mty = mty;
      @(posedge CLK); #1;
      rx_ena = '0; rx_sop = '0; rx_eop = '0; rx_err = '0; rx_mty = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge CLK); #1; end
   endtask

   task automatic snap();
      snapshot = 1'b1;
      @(posedge CLK); #1;
      snapshot = 1'b0;
   endtask

   task automatic clr();
      clear = 1'b1;
      @(posedge CLK); #1;
      clear = 1'b0;
   endtask

   task automatic check_cnt(input string t, input logic [63:0] f, input logic [63:0] b,
                            input logic [63:0] e, input logic [63:0] r, input logic [63:0] o);
      check_eq({t, ".frames"}, 64'(c_frames), f);
      check_eq({t, ".bytes"},  64'(c_bytes),  b);
      check_eq({t, ".err"},    64'(c_err),    e);
      check_eq({t, ".runt"},   64'(c_runt),   r);
      check_eq({t, ".over"},   64'(c_over),   o);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET_N = 1'b0;
      rx_ena = '0; rx_sop = '0; rx_eop = '0; rx_err = '0; rx_mty = '0;
      snapshot = 1'b0; clear = 1'b0;
      #12;
      check_cnt("reset", 0, 0, 0, 0, 0);
      check_eq("reset.snap_valid", 64'(snap_valid), 0);
      check_eq("reset.viol", 64'(viol), 0);
      #10 RESET_N = 1'b1;
      @(posedge CLK); #1;

      // 64B frame; snapshot one cycle later misses it, two cycles later sees it
      drive(4'b1111, 4'b0001, 4'b1000, 4'b0000, 16'h0000);
      snap();
      check_eq("lat.early_frames", 64'(c_frames), 0);
      check_eq("lat.snap_valid", 64'(snap_valid), 1);
      snap();
      check_cnt("t1", 1, 64, 0, 0, 0);
      check_eq("t1.viol", 64'(viol), 0);
      idle(1);
      check_eq("t1.snap_valid_drop", 64'(snap_valid), 0);

      // 60B frame, then a 17B frame split over two cycles
      clr();
      drive(4'b1111, 4'b0001, 4'b1000, 4'b0000, 16'h4000);
      drive(4'b0001, 4'b0001, 4'b0000, 4'b0000, 16'h0000);
      drive(4'b0001, 4'b0000, 4'b0001, 4'b0000, 16'h000F);
      idle(2); snap();
      check_cnt("t2", 2, 77, 0, 2, 0);
      check_eq("t2.viol", 64'(viol), 0);

      // four single-segment frames in one cycle, seg2 errored
      clr();
      drive(4'b1111, 4'b1111, 4'b1111, 4'b0100, 16'h0000);
      idle(2); snap();
      check_cnt("t3", 3, 48, 1, 4, 0);

      // SOP while in frame, then non-contiguous ENA
      clr();
      drive(4'b0001, 4'b0001, 4'b0000, 4'b0000, 16'h0000);
      drive(4'b0001, 4'b0001, 4'b0000, 4'b0000, 16'h0000);
      drive(4'b1010, 4'b0000, 4'b0000, 4'b0000, 16'h0000);
      idle(2); snap();
      check_eq("t4.viol", 64'(viol), 64'h5);
      check_eq("t4.err", 64'(c_err), 1);
      check_eq("t4.frames_open", 64'(c_frames), 0);
      drive(4'b0001, 4'b0000, 4'b0001, 4'b0000, 16'h0000);
      idle(2); snap();
      check_eq("t4.frames", 64'(c_frames), 1);
      check_eq("t4.bytes", 64'(c_bytes), 64);

      // ENA without SOP while idle, MTY without EOP
      clr();
      drive(4'b0001, 4'b0000, 4'b0000, 4'b0000, 16'h0003);
      idle(2); snap();
      check_eq("t4b.viol", 64'(viol), 64'hA);
      check_eq("t4b.frames", 64'(c_frames), 0);

      // MTU boundary: 16384 oversize, 16383 not
      clr();
      drive(4'b1111, 4'b0001, 4'b0000, 4'b0000, 16'h0000);
      repeat (254) drive(4'b1111, 4'b0000, 4'b0000, 4'b0000, 16'h0000);
      drive(4'b1111, 4'b0000, 4'b1000, 4'b0000, 16'h0000);
      drive(4'b1111, 4'b0001, 4'b0000, 4'b0000, 16'h0000);
      repeat (254) drive(4'b1111, 4'b0000, 4'b0000, 4'b0000, 16'h0000);
      drive(4'b1111, 4'b0000, 4'b1000, 4'b0000, 16'h1000);
      idle(2); snap();
      check_cnt("mtu", 2, 32767, 0, 0, 1);

      // saturation on the 8-bit instance: 256 + 3 frames
      clr();
      repeat (64) drive(4'b1111, 4'b1111, 4'b1111, 4'b0000, 16'h0000);
      drive(4'b0111, 4'b0111, 4'b0111, 4'b0000, 16'h0000);
      idle(2); snap();
      check_eq("t5.sat_frames", 64'(s_frames), 255);
      check_eq("t5.sat_bytes", 64'(s_bytes), 255);
      check_eq("t5.sat_runt", 64'(s_runt), 255);
      check_eq("t5.sat_err", 64'(s_err), 0);
      check_eq("t5.wide_frames", 64'(c_frames), 259);
      check_eq("t5.wide_bytes", 64'(c_bytes), 4144);

      // snapshot and clear together capture pre-clear values
      clr();
      drive(4'b1111, 4'b1111, 4'b1111, 4'b0000, 16'h0000);
      drive(4'b0010, 4'b0010, 4'b0010, 4'b0000, 16'h0000);
      idle(2);
      check_eq("t6.viol_pre", 64'(viol), 64'h4);
      snapshot = 1'b1; clear = 1'b1;
      @(posedge CLK); #1;
      snapshot = 1'b0; clear = 1'b0;
      check_cnt("t6.pre", 5, 80, 0, 5, 0);
      check_eq("t6.viol_clr", 64'(viol), 0);
      idle(1); snap();
      check_cnt("t6.post", 0, 0, 0, 0, 0);

      // reset mid-frame, then a continuation segment is a violation
      clr();
      drive(4'b0001, 4'b0001, 4'b0000, 4'b0000, 16'h0000);
      snap();
      RESET_N = 1'b0;
      #2;
      check_eq("rst.viol", 64'(viol), 0);
      check_eq("rst.snap_valid", 64'(snap_valid), 0);
      #1 RESET_N = 1'b1;
      drive(4'b0001, 4'b0000, 4'b0001, 4'b0000, 16'h0000);
      idle(2); snap();
      check_eq("rst.viol_after", 64'(viol), 64'h2);
      check_cnt("rst", 0, 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
